// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - funct codes, FSM state type and step count for the EX-stage multiply/divide unit
package muldiv_pkg;

    localparam int MULDIV_STEPS = 32;

    localparam logic [5:0] FUN_MFHI  = 6'h10;
    localparam logic [5:0] FUN_MTHI  = 6'h11;
    localparam logic [5:0] FUN_MFLO  = 6'h12;
    localparam logic [5:0] FUN_MTLO  = 6'h13;
    localparam logic [5:0] FUN_MULT  = 6'h18;
    localparam logic [5:0] FUN_MULTU = 6'h19;
    localparam logic [5:0] FUN_DIV   = 6'h1A;
    localparam logic [5:0] FUN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational radix-2 multiply (shift-add) or divide (restoring) step
// Divide path present only when MULDIV_DIV_EN is defined.
module muldiv_step #(
    parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
    input  logic             isDiv,
`endif
    input  logic [WIDTH-1:0] accHi,
    input  logic [WIDTH-1:0] accLo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nextHi,
    output logic [WIDTH-1:0] nextLo
);

    logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
`endif

    always_comb begin
        // Multiply: LO holds the not-yet-consumed multiplier bits; product shifts in from the top.
        sum    = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        nextHi = sum[WIDTH:1];
        nextLo = {sum[0], accLo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        shifted = {accHi, accLo[WIDTH-1]};
        trial   = shifted - {1'b0, operand};
        if (isDiv) begin
            if (!trial[WIDTH]) begin
                nextHi = trial[WIDTH-1:0];
                nextLo = {accLo[WIDTH-2:0], 1'b1};
            end else begin
                nextHi = shifted[WIDTH-1:0];
                nextLo = {accLo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and HI/LO-hazard stall
// Define MULDIV_DIV_EN to build the divide datapath; otherwise DIV/DIVU are no-ops.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_STEPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iValid,
    input  logic             iFlush,
    input  logic             iHold,
    input  logic [5:0]       iFun,
    input  logic [WIDTH-1:0] iRegOut1,
    input  logic [WIDTH-1:0] iRegOut2,
    output logic             oStall,
    output logic             oBusy,
    output logic [WIDTH-1:0] oResult,
    output logic [WIDTH-1:0] oHi,
    output logic [WIDTH-1:0] oLo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    muldiv_state_t    state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hiReg, loReg;
    logic [WIDTH-1:0] accHi, accLo, operand;
    logic             negLo;
`ifdef MULDIV_DIV_EN
    logic             isDiv;
    logic             negHi;
    logic             divZero;
`endif

    logic             isMoveFun, isMulFun, isDivFun, isSignedFun, hiLoOp, live, accept;
    logic             signA, signB;
    logic [WIDTH-1:0] magA, magB;
    logic [WIDTH-1:0] stepHi, stepLo;
    logic [WIDTH-1:0] fixHi, fixLo;
    logic [2*WIDTH-1:0] prod, prodNeg;

    always_comb begin
        isMoveFun = (iFun == FUN_MFHI) || (iFun == FUN_MTHI) ||
                    (iFun == FUN_MFLO) || (iFun == FUN_MTLO);
        isMulFun  = (iFun == FUN_MULT) || (iFun == FUN_MULTU);
        isDivFun  = (iFun == FUN_DIV)  || (iFun == FUN_DIVU);
`ifdef MULDIV_DIV_EN
        hiLoOp    = isMoveFun || isMulFun || isDivFun;
`else
        // Without a divider, DIV/DIVU only matter as ordering barriers behind a running multiply.
        hiLoOp    = isMoveFun || isMulFun || (isDivFun && (state != IDLE));
`endif
        live      = iValid && !iFlush && hiLoOp;
        oStall    = live && (state != IDLE);
        accept    = live && !iHold && (state == IDLE);
        oBusy     = (state != IDLE);

        isSignedFun = (iFun == FUN_MULT) || (iFun == FUN_DIV);
        signA       = isSignedFun && iRegOut1[WIDTH-1];
        signB       = isSignedFun && iRegOut2[WIDTH-1];
        magA        = signA ? -iRegOut1 : iRegOut1;
        magB        = signB ? -iRegOut2 : iRegOut2;
    end

    always_comb begin
        prod    = {accHi, accLo};
        prodNeg = -prod;
        fixHi   = negLo ? prodNeg[2*WIDTH-1:WIDTH] : accHi;
        fixLo   = negLo ? prodNeg[WIDTH-1:0] : accLo;
`ifdef MULDIV_DIV_EN
        if (isDiv) begin
            // A zero divisor leaves |dividend| in HI; re-applying the dividend sign restores it exactly.
            fixHi = negHi ? -accHi : accHi;
            fixLo = divZero ? {WIDTH{1'b1}} : (negLo ? -accLo : accLo);
        end
`endif
    end

    always_comb begin
        oResult = '0;
        if (iValid && !iFlush) begin
            if (iFun == FUN_MFHI) begin
                oResult = hiReg;
            end else if (iFun == FUN_MFLO) begin
                oResult = loReg;
            end
        end
    end

    assign oHi = hiReg;
    assign oLo = loReg;

    muldiv_step #(.WIDTH(WIDTH)) uStep (
`ifdef MULDIV_DIV_EN
        .isDiv   (isDiv),
`endif
        .accHi   (accHi),
        .accLo   (accLo),
        .operand (operand),
        .nextHi  (stepHi),
        .nextLo  (stepLo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            accHi   <= '0;
            accLo   <= '0;
            operand <= '0;
            negLo   <= 1'b0;
`ifdef MULDIV_DIV_EN
            isDiv   <= 1'b0;
            negHi   <= 1'b0;
            divZero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (isMulFun) begin
                            accHi   <= '0;
                            accLo   <= magB;
                            operand <= magA;
                            negLo   <= signA ^ signB;
                            cnt     <= '0;
                            state   <= BUSY;
`ifdef MULDIV_DIV_EN
                            isDiv   <= 1'b0;
                        end else if (isDivFun) begin
                            accHi   <= '0;
                            accLo   <= magA;
                            operand <= magB;
                            negLo   <= signA ^ signB;
                            negHi   <= signA;
                            divZero <= (iRegOut2 == '0);
                            isDiv   <= 1'b1;
                            cnt     <= '0;
                            state   <= BUSY;
`endif
                        end else if (iFun == FUN_MTHI) begin
                            hiReg <= iRegOut1;
                        end else if (iFun == FUN_MTLO) begin
                            loReg <= iRegOut1;
                        end
                    end
                end
                BUSY: begin
                    accHi <= stepHi;
                    accLo <= stepLo;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hiReg <= fixHi;
                    loReg <= fixLo;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed self-checking bench for ex_muldiv
module tb_ex_muldiv;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         iValid, iFlush, iHold;
    logic [5:0]   iFun;
    logic [W-1:0] iRegOut1, iRegOut2;
    logic         oStall, oBusy;
    logic [W-1:0] oResult, oHi, oLo;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .iValid   (iValid),
        .iFlush   (iFlush),
        .iHold    (iHold),
        .iFun     (iFun),
        .iRegOut1 (iRegOut1),
        .iRegOut2 (iRegOut2),
        .oStall   (oStall),
        .oBusy    (oBusy),
        .oResult  (oResult),
        .oHi      (oHi),
        .oLo      (oLo)
    );

    task automatic issue(input logic [5:0] fun, input logic [W-1:0] a, input logic [W-1:0] b);
        iValid = 1'b1; iFun = fun; iRegOut1 = a; iRegOut2 = b;
        @(posedge clk); #1;
        iValid = 1'b0;
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (oBusy === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; iValid = 1'b0; iFlush = 1'b0; iHold = 1'b0;
        iFun = '0; iRegOut1 = '0; iRegOut2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tests++; if (oBusy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", oBusy); end
        tests++; if (oStall !== 1'b0) begin fails++; $display("FAIL reset_stall got %0b want 0", oStall); end
        tests++; if (oHi !== 32'h0 || oLo !== 32'h0) begin fails++; $display("FAIL reset_hilo got %h/%h want 0/0", oHi, oLo); end
        iValid = 1'b1; iFun = FUN_MFLO; #1;
        tests++; if (oResult !== 32'h0 || oStall !== 1'b0) begin fails++; $display("FAIL reset_mflo got res=%h stall=%0b want 0/0", oResult, oStall); end
        iValid = 1'b0;
    endtask

    task automatic test_mult();
        int n;
        issue(FUN_MULT, 32'hFFFFFFFD, 32'd5);
        repeat (32) @(posedge clk);
        #1;
        tests++; if (oBusy !== 1'b1 || oHi !== 32'h0 || oLo !== 32'h0) begin
            fails++; $display("FAIL mult_e32 got busy=%0b hi=%h lo=%h want 1/0/0", oBusy, oHi, oLo); end
        @(posedge clk); #1;
        tests++; if (oBusy !== 1'b0) begin fails++; $display("FAIL mult_e33_busy got %0b want 0", oBusy); end
        tests++; if (oHi !== 32'hFFFFFFFF || oLo !== 32'hFFFFFFF1) begin
            fails++; $display("FAIL mult_neg got %h/%h want ffffffff/fffffff1", oHi, oLo); end
        issue(FUN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitIdle(n);
        tests++; if (n !== 33) begin fails++; $display("FAIL multu_busy got %0d want 33", n); end
        tests++; if (oHi !== 32'hFFFFFFFE || oLo !== 32'h00000001) begin
            fails++; $display("FAIL multu got %h/%h want fffffffe/00000001", oHi, oLo); end
    endtask

    task automatic test_stall_mflo();
        int s, b;
        issue(FUN_MULT, 32'd6, 32'd7);
        iValid = 1'b1; iFun = FUN_MFLO; #1;
        s = 0; b = 0;
        while (oStall === 1'b1 && s < 100) begin
            s++;
            if (oBusy === 1'b1) b++;
            @(posedge clk); #1;
        end
        tests++; if (s !== 33) begin fails++; $display("FAIL mflo_stall_cycles got %0d want 33", s); end
        tests++; if (b !== 33) begin fails++; $display("FAIL mflo_busy_cycles got %0d want 33", b); end
        tests++; if (oResult !== 32'd42) begin fails++; $display("FAIL mflo_result got %h want 0000002a", oResult); end
        @(posedge clk); #1;
        iValid = 1'b0;
    endtask

    task automatic test_move();
        issue(FUN_MTHI, 32'h1234, 32'h0);
        iValid = 1'b1; iFun = FUN_MFHI; #1;
        tests++; if (oResult !== 32'h1234 || oStall !== 1'b0 || oBusy !== 1'b0) begin
            fails++; $display("FAIL mthi_mfhi got res=%h stall=%0b busy=%0b want 1234/0/0", oResult, oStall, oBusy); end
        iValid = 1'b0;
        issue(FUN_MTLO, 32'hABCD, 32'h0);
        iValid = 1'b1; iFun = FUN_MFLO; #1;
        tests++; if (oResult !== 32'hABCD || oHi !== 32'h1234) begin
            fails++; $display("FAIL mtlo_mflo got res=%h hi=%h want abcd/1234", oResult, oHi); end
        iValid = 1'b0;
    endtask

    task automatic test_flush();
        int bad;
        iFlush = 1'b1;
        issue(FUN_MULT, 32'd2, 32'd3);
        bad = 0;
        repeat (3) begin
            if (oBusy !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        iFlush = 1'b0;
        tests++; if (bad !== 0) begin fails++; $display("FAIL flush_busy got %0d busy cycles want 0", bad); end
        tests++; if (oHi !== 32'h1234 || oLo !== 32'hABCD) begin
            fails++; $display("FAIL flush_hilo got %h/%h want 1234/abcd", oHi, oLo); end
    endtask

    task automatic test_hold();
        int bad, n;
        iHold = 1'b1; iValid = 1'b1; iFun = FUN_MULT; iRegOut1 = 32'd4; iRegOut2 = 32'd4;
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (oBusy !== 1'b0 || oStall !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL hold_noaccept got %0d bad cycles want 0", bad); end
        iHold = 1'b0;
        @(posedge clk); #1;
        tests++; if (oBusy !== 1'b1) begin fails++; $display("FAIL hold_release_busy got %0b want 1", oBusy); end
        iHold = 1'b1; iFun = FUN_MFHI; #1;
        tests++; if (oStall !== 1'b1) begin fails++; $display("FAIL hold_stall got %0b want 1", oStall); end
        iFlush = 1'b1; #1;
        tests++; if (oStall !== 1'b0) begin fails++; $display("FAIL flush_nostall got %0b want 0", oStall); end
        iFlush = 1'b0; iHold = 1'b0; iValid = 1'b0;
        waitIdle(n);
        tests++; if (n !== 33 || oHi !== 32'h0 || oLo !== 32'd16) begin
            fails++; $display("FAIL hold_mult got n=%0d hi=%h lo=%h want 33/0/10", n, oHi, oLo); end
    endtask

    task automatic test_back_to_back();
        int s, n;
        issue(FUN_MULT, 32'hFFFFFFFF, 32'h10);
        iValid = 1'b1; iFun = FUN_MULTU; iRegOut1 = 32'd3; iRegOut2 = 32'd4; #1;
        s = 0;
        while (oStall === 1'b1 && s < 100) begin
            s++;
            @(posedge clk); #1;
        end
        tests++; if (s !== 33) begin fails++; $display("FAIL b2b_stall got %0d want 33", s); end
        tests++; if (oHi !== 32'hFFFFFFFF || oLo !== 32'hFFFFFFF0) begin
            fails++; $display("FAIL b2b_first got %h/%h want ffffffff/fffffff0", oHi, oLo); end
        @(posedge clk); #1;
        iValid = 1'b0;
        waitIdle(n);
        tests++; if (n !== 33 || oHi !== 32'h0 || oLo !== 32'd12) begin
            fails++; $display("FAIL b2b_second got n=%0d hi=%h lo=%h want 33/0/c", n, oHi, oLo); end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div();
        int n;
        issue(FUN_DIV, 32'hFFFFFFF9, 32'd2);
        waitIdle(n);
        tests++; if (n !== 33) begin fails++; $display("FAIL div_busy got %0d want 33", n); end
        tests++; if (oHi !== 32'hFFFFFFFF || oLo !== 32'hFFFFFFFD) begin
            fails++; $display("FAIL div_neg got %h/%h want ffffffff/fffffffd", oHi, oLo); end
        issue(FUN_DIVU, 32'd7, 32'd0);
        waitIdle(n);
        tests++; if (n !== 33 || oHi !== 32'd7 || oLo !== 32'hFFFFFFFF) begin
            fails++; $display("FAIL divu_zero got n=%0d hi=%h lo=%h want 33/7/ffffffff", n, oHi, oLo); end
        issue(FUN_DIV, 32'h80000000, 32'hFFFFFFFF);
        waitIdle(n);
        tests++; if (oHi !== 32'h0 || oLo !== 32'h80000000) begin
            fails++; $display("FAIL div_ovf got %h/%h want 0/80000000", oHi, oLo); end
        issue(FUN_DIV, 32'hFFFFFFFB, 32'd0);
        waitIdle(n);
        tests++; if (oHi !== 32'hFFFFFFFB || oLo !== 32'hFFFFFFFF) begin
            fails++; $display("FAIL div_zero_signed got %h/%h want fffffffb/ffffffff", oHi, oLo); end
    endtask
`else
    task automatic test_div_disabled();
        int bad, n;
        issue(FUN_DIV, 32'd9, 32'd3);
        bad = 0;
        repeat (3) begin
            if (oBusy !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL nodiv_busy got %0d busy cycles want 0", bad); end
        tests++; if (oHi !== 32'h0 || oLo !== 32'd12) begin
            fails++; $display("FAIL nodiv_hilo got %h/%h want 0/c", oHi, oLo); end
        issue(FUN_MULT, 32'd2, 32'd3);
        iValid = 1'b1; iFun = FUN_DIV; iRegOut1 = 32'd9; iRegOut2 = 32'd3; #1;
        tests++; if (oStall !== 1'b1) begin fails++; $display("FAIL nodiv_stall got %0b want 1", oStall); end
        iValid = 1'b0;
        waitIdle(n);
        tests++; if (n !== 33 || oLo !== 32'd6) begin
            fails++; $display("FAIL nodiv_mult got n=%0d lo=%h want 33/6", n, oLo); end
    endtask
`endif

    task automatic test_reset_mid();
`ifdef MULDIV_DIV_EN
        issue(FUN_DIV, 32'd100, 32'd7);
`else
        issue(FUN_MULT, 32'd100, 32'd7);
`endif
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        iValid = 1'b1; iFun = FUN_MFHI; #1;
        tests++; if (oBusy !== 1'b0 || oStall !== 1'b0) begin
            fails++; $display("FAIL rstmid_idle got busy=%0b stall=%0b want 0/0", oBusy, oStall); end
        tests++; if (oHi !== 32'h0 || oLo !== 32'h0 || oResult !== 32'h0) begin
            fails++; $display("FAIL rstmid_hilo got %h/%h res=%h want 0/0/0", oHi, oLo, oResult); end
        iValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (oBusy !== 1'b0 || oHi !== 32'h0) begin
            fails++; $display("FAIL rstmid_stays got busy=%0b hi=%h want 0/0", oBusy, oHi); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_stall_mflo();
        test_move();
        test_flush();
        test_hold();
        test_back_to_back();
`ifdef MULDIV_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
